// File: rtl/part_evt_pkg.sv
// Shared types, default parameters and helpers for the part event monitor.
package part_evt_pkg;

  localparam int CNT_W_DEF       = 8;
  localparam int TS_W_DEF        = 8;
  localparam int FIFO_DEPTH_DEF  = 4;
  localparam int SYNC_STAGES_DEF = 2;

  // Event record layout at the default timestamp width.
  typedef struct packed {
    logic [TS_W_DEF-1:0] ts;
    logic                y_rise;
    logic                x_rise;
  } evt_rec_t;

  // Increment, holding at the all-ones value of a 'width'-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] count, input int width);
    logic [31:0] max_v;
    max_v = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (count >= max_v) ? count : count + 32'd1;
  endfunction

endpackage

// File: rtl/part_evt_fifo.sv
// Show-ahead FIFO: dout is the head entry whenever empty is low.
module part_evt_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [AW-1:0]           wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]             cnt_q, cnt_d;
  logic                    do_push, do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign dout  = mem_q[rd_q];

  // A push into a full FIFO is only taken when a pop frees the head slot in the same cycle.
  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + AW'(1);
    end
    if (do_pop) rd_d = rd_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage and pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/part_event_monitor.sv
// Synchronises xPart/yPart, counts their rising edges and queues timestamped records.
module part_event_monitor
  import part_evt_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int TS_W        = TS_W_DEF,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x_in,
  input  logic             y_in,
  input  logic             clr,
  output logic [CNT_W-1:0] x_count,
  output logic [CNT_W-1:0] y_count,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [TS_W+1:0]  evt_data,
  output logic             evt_drop
);
  logic [1:0]       in_raw, rise;
  logic [CNT_W-1:0] x_cnt_q, x_cnt_d, y_cnt_q, y_cnt_d;
  logic [TS_W-1:0]  ts_q, ts_d;
  logic             drop_q, drop_d;
  logic             push, pop, drop, fifo_empty, fifo_full;

  assign in_raw = {y_in, x_in};

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;

    // Shift the raw line through the chain; hist holds the previous synchronised level.
    always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], in_raw[ch]};
      hist_d = sync_q[SYNC_STAGES-1];
    end

    // Chain and history reset low so a line high at reset release gives one rise.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_q <= '0;
        hist_q <= 1'b0;
      end else begin
        sync_q <= sync_d;
        hist_q <= hist_d;
      end
    end

    assign rise[ch] = sync_q[SYNC_STAGES-1] & ~hist_q;
  end

  assign push = |rise;
  assign pop  = evt_valid & evt_ready;
  assign drop = push & fifo_full & ~pop;

  // Counters (clr beats a same-cycle rise), free-running timestamp, sticky drop (drop beats clr).
  always_comb begin
    x_cnt_d = x_cnt_q;
    y_cnt_d = y_cnt_q;
    if (clr) begin
      x_cnt_d = '0;
      y_cnt_d = '0;
    end else begin
      if (rise[0]) x_cnt_d = CNT_W'(sat_inc(32'(x_cnt_q), CNT_W));
      if (rise[1]) y_cnt_d = CNT_W'(sat_inc(32'(y_cnt_q), CNT_W));
    end
    ts_d   = ts_q + TS_W'(1);
    drop_d = drop ? 1'b1 : (clr ? 1'b0 : drop_q);
  end

  // Counter, timestamp and drop-flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_cnt_q <= '0;
      y_cnt_q <= '0;
      ts_q    <= '0;
      drop_q  <= 1'b0;
    end else begin
      x_cnt_q <= x_cnt_d;
      y_cnt_q <= y_cnt_d;
      ts_q    <= ts_d;
      drop_q  <= drop_d;
    end
  end

  part_evt_fifo #(
    .W     (TS_W + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({ts_q, rise[1], rise[0]}),
    .pop   (pop),
    .dout  (evt_data),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign x_count   = x_cnt_q;
  assign y_count   = y_cnt_q;
  assign evt_valid = ~fifo_empty;
  assign evt_drop  = drop_q;

endmodule

// File: tb/tb_part_event_monitor.sv
// Self-checking bench for part_event_monitor against an event-level reference model.
module tb_part_event_monitor;
  import part_evt_pkg::*;

  localparam int S     = SYNC_STAGES_DEF;
  localparam int DEPTH = FIFO_DEPTH_DEF;

  logic       clk = 1'b0, rst = 1'b1, x_in = 1'b0, y_in = 1'b0, clr = 1'b0, evt_ready = 1'b0;
  logic [7:0] x_count, y_count;
  logic [1:0] x_count2, y_count2;
  logic       evt_valid, evt_drop, evt_valid2, evt_drop2;
  logic [9:0] evt_data, evt_data2;

  int errors = 0, checks = 0;

  // Reference model state: samples taken at each edge since reset, expected queue and counts.
  int         n;
  bit         xs[$], ys[$];
  logic [9:0] mq[$];
  int         m_xc, m_yc, m_xc2, m_yc2;
  bit         m_drop;

  part_event_monitor u_dut (
    .clk(clk), .rst(rst), .x_in(x_in), .y_in(y_in), .clr(clr),
    .x_count(x_count), .y_count(y_count), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_data(evt_data), .evt_drop(evt_drop)
  );

  part_event_monitor #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .x_in(x_in), .y_in(y_in), .clr(clr),
    .x_count(x_count2), .y_count(y_count2), .evt_valid(evt_valid2), .evt_ready(evt_ready),
    .evt_data(evt_data2), .evt_drop(evt_drop2)
  );

  always #5 clk = ~clk;

  function automatic bit smp(input bit is_y, input int k);
    if (k < 1 || k > n) return 1'b0;
    return is_y ? ys[k-1] : xs[k-1];
  endfunction

  task automatic model_clear();
    n = 0; xs.delete(); ys.delete(); mq.delete();
    m_xc = 0; m_yc = 0; m_xc2 = 0; m_yc2 = 0; m_drop = 1'b0;
  endtask

  // One clock: a line level sampled at edge k is seen as a rise at edge k+S if it was low at k-1.
  task automatic tick();
    bit xr, yr, pop, drop;
    @(posedge clk);
    n++; xs.push_back(x_in); ys.push_back(y_in);
    xr = smp(1'b0, n-S) & ~smp(1'b0, n-S-1);
    yr = smp(1'b1, n-S) & ~smp(1'b1, n-S-1);
    pop = (mq.size() > 0) && evt_ready;
    if (pop) void'(mq.pop_front());
    drop = 1'b0;
    if (xr || yr) begin
      if (mq.size() < DEPTH) mq.push_back({8'(n-1), yr, xr});
      else drop = 1'b1;
    end
    if (drop) m_drop = 1'b1; else if (clr) m_drop = 1'b0;
    if (clr) begin m_xc = 0; m_yc = 0; m_xc2 = 0; m_yc2 = 0; end
    else begin
      if (xr) begin m_xc = (m_xc < 255) ? m_xc + 1 : 255; m_xc2 = (m_xc2 < 3) ? m_xc2 + 1 : 3; end
      if (yr) begin m_yc = (m_yc < 255) ? m_yc + 1 : 255; m_yc2 = (m_yc2 < 3) ? m_yc2 + 1 : 3; end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic pulse_x();
    x_in = 1'b1; repeat (3) tick();
    x_in = 1'b0; repeat (3) tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (x_count !== 8'd0) begin errors++; $display("FAIL reset_x_count: got %0d want 0", x_count); end
    checks++; if (y_count !== 8'd0) begin errors++; $display("FAIL reset_y_count: got %0d want 0", y_count); end
    checks++; if (x_count2 !== 2'd0) begin errors++; $display("FAIL reset_x_count2: got %0d want 0", x_count2); end
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", evt_valid); end
    checks++; if (evt_data !== 10'h000) begin errors++; $display("FAIL reset_data: got %0h want 0", evt_data); end
    checks++; if (evt_drop !== 1'b0) begin errors++; $display("FAIL reset_drop: got %0b want 0", evt_drop); end
  endtask

  task automatic test_single_rise();
    x_in = 1'b1;
    tick(); tick();
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %0b want 0", evt_valid); end
    checks++; if (x_count !== 8'd0) begin errors++; $display("FAIL single_early_cnt: got %0d want 0", x_count); end
    tick();
    checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b want 1", evt_valid); end
    checks++; if (x_count !== 8'd1) begin errors++; $display("FAIL single_cnt: got %0d want 1", x_count); end
    checks++; if (evt_data !== {8'd2, 2'b01}) begin errors++; $display("FAIL single_data: got %0h want %0h", evt_data, {8'd2, 2'b01}); end
    repeat (5) tick();
    checks++; if (x_count !== 8'd1) begin errors++; $display("FAIL single_hold_cnt: got %0d want 1", x_count); end
    x_in = 1'b0; evt_ready = 1'b1;
    repeat (3) tick();
    evt_ready = 1'b0;
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %0b want 0", evt_valid); end
  endtask

  task automatic test_simultaneous();
    x_in = 1'b1; y_in = 1'b1;
    repeat (4) tick();
    checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL simul_valid: got %0b want 1", evt_valid); end
    checks++; if (evt_data[1:0] !== 2'b11) begin errors++; $display("FAIL simul_bits: got %0b want 11", evt_data[1:0]); end
    checks++; if (y_count !== 8'd1) begin errors++; $display("FAIL simul_y_cnt: got %0d want 1", y_count); end
    checks++; if (x_count !== 8'(m_xc)) begin errors++; $display("FAIL simul_x_cnt: got %0d want %0d", x_count, m_xc); end
    x_in = 1'b0; y_in = 1'b0; evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL simul_single_rec: got %0b want 0", evt_valid); end
  endtask

  task automatic test_overflow();
    int pops;
    clr = 1'b1; tick(); clr = 1'b0;
    for (int p = 0; p < 6; p++) begin
      pulse_x();
      checks++; if (evt_drop !== (p >= 4)) begin errors++; $display("FAIL ovf_drop_%0d: got %0b want %0b", p, evt_drop, p >= 4); end
    end
    checks++; if (x_count !== 8'd6) begin errors++; $display("FAIL ovf_x_cnt: got %0d want 6", x_count); end
    evt_ready = 1'b1; pops = 0;
    for (int i = 0; i < 10; i++) begin
      if (evt_valid) begin
        checks++; if (evt_data !== mq[0]) begin errors++; $display("FAIL ovf_pop_data_%0d: got %0h want %0h", i, evt_data, mq[0]); end
        pops++;
      end
      tick();
    end
    evt_ready = 1'b0;
    checks++; if (pops != 4) begin errors++; $display("FAIL ovf_pop_count: got %0d want 4", pops); end
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: got %0b want 0", evt_valid); end
  endtask

  task automatic test_push_pop_full();
    logic [9:0] newest;
    int pops;
    clr = 1'b1; tick(); clr = 1'b0;
    repeat (DEPTH) pulse_x();
    x_in = 1'b1; tick(); tick();
    evt_ready = 1'b1; tick(); evt_ready = 1'b0;
    x_in = 1'b0;
    newest = {8'(n-1), 2'b01};
    checks++; if (evt_drop !== 1'b0) begin errors++; $display("FAIL ppf_drop: got %0b want 0", evt_drop); end
    evt_ready = 1'b1; pops = 0;
    for (int i = 0; i < 8 && evt_valid; i++) begin
      pops++;
      if (pops == DEPTH) begin
        checks++; if (evt_data !== newest) begin errors++; $display("FAIL ppf_last: got %0h want %0h", evt_data, newest); end
      end
      tick();
    end
    evt_ready = 1'b0;
    checks++; if (pops != DEPTH) begin errors++; $display("FAIL ppf_occupancy: got %0d want %0d", pops, DEPTH); end
  endtask

  task automatic test_saturate();
    int exp2[5];
    exp2 = '{1, 2, 3, 3, 3};
    clr = 1'b1; tick(); clr = 1'b0;
    evt_ready = 1'b1;
    for (int p = 0; p < 5; p++) begin
      pulse_x();
      checks++; if (x_count2 !== 2'(exp2[p])) begin errors++; $display("FAIL sat_cnt2_%0d: got %0d want %0d", p, x_count2, exp2[p]); end
    end
    checks++; if (x_count !== 8'd5) begin errors++; $display("FAIL sat_cnt8: got %0d want 5", x_count); end
    evt_ready = 1'b0;
    x_in = 1'b1; tick(); tick();
    clr = 1'b1; tick(); clr = 1'b0;
    checks++; if (x_count !== 8'd0) begin errors++; $display("FAIL clr_rise_cnt: got %0d want 0", x_count); end
    checks++; if (x_count2 !== 2'd0) begin errors++; $display("FAIL clr_rise_cnt2: got %0d want 0", x_count2); end
    checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL clr_rise_push: got %0b want 1", evt_valid); end
    checks++; if (evt_data[1:0] !== 2'b01) begin errors++; $display("FAIL clr_rise_bits: got %0b want 01", evt_data[1:0]); end
    x_in = 1'b0; evt_ready = 1'b1; repeat (3) tick(); evt_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    repeat (3) pulse_x();
    checks++; if (evt_valid !== 1'b1) begin errors++; $display("FAIL rmid_queued: got %0b want 1", evt_valid); end
    x_in = 1'b1; tick();
    rst = 1'b1; #1;
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %0b want 0", evt_valid); end
    checks++; if (x_count !== 8'd0) begin errors++; $display("FAIL rmid_cnt: got %0d want 0", x_count); end
    checks++; if (x_count2 !== 2'd0) begin errors++; $display("FAIL rmid_cnt2: got %0d want 0", x_count2); end
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) tick();
    checks++; if (x_count !== 8'd1) begin errors++; $display("FAIL rmid_rise: got %0d want 1", x_count); end
    repeat (3) tick();
    checks++; if (x_count !== 8'd1) begin errors++; $display("FAIL rmid_hold: got %0d want 1", x_count); end
    x_in = 1'b0; evt_ready = 1'b1; repeat (3) tick(); evt_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      x_in = 1'($urandom_range(0, 1));
      y_in = 1'($urandom_range(0, 1));
      clr  = ($urandom_range(0, 19) == 0);
      evt_ready = (i < 200) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
      tick();
      checks++; if (x_count !== 8'(m_xc)) begin errors++; $display("FAIL rnd_x_cnt@%0d: got %0d want %0d", i, x_count, m_xc); end
      checks++; if (y_count !== 8'(m_yc)) begin errors++; $display("FAIL rnd_y_cnt@%0d: got %0d want %0d", i, y_count, m_yc); end
      checks++; if (x_count2 !== 2'(m_xc2)) begin errors++; $display("FAIL rnd_x_cnt2@%0d: got %0d want %0d", i, x_count2, m_xc2); end
      checks++; if (y_count2 !== 2'(m_yc2)) begin errors++; $display("FAIL rnd_y_cnt2@%0d: got %0d want %0d", i, y_count2, m_yc2); end
      checks++; if (evt_valid !== (mq.size() > 0)) begin errors++; $display("FAIL rnd_valid@%0d: got %0b want %0b", i, evt_valid, mq.size() > 0); end
      checks++; if (evt_drop !== m_drop) begin errors++; $display("FAIL rnd_drop@%0d: got %0b want %0b", i, evt_drop, m_drop); end
      if (mq.size() > 0) begin
        checks++; if (evt_data !== mq[0]) begin errors++; $display("FAIL rnd_data@%0d: got %0h want %0h", i, evt_data, mq[0]); end
      end
    end
    clr = 1'b0; evt_ready = 1'b0; x_in = 1'b0; y_in = 1'b0;
  endtask

  initial begin
    model_clear();
    test_reset();
    test_single_rise();
    test_simultaneous();
    test_overflow();
    test_push_pop_full();
    test_saturate();
    test_reset_mid();
    do_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
